// File: rtl/gshare_pkg.sv
// -----------------------------------------------------------------------------
// gshare_pkg
//   Shared definitions for the gshare access controller slice.
//   - GS_ADDR_W  : default branch address width (matches the predictor port)
//   - gs_state_e : controller FSM encoding (IDLE/LOOKUP/CAPTURE/UPDATE)
//   - gs_entry_t : one in-flight queue entry {addr, pred} at default width
// -----------------------------------------------------------------------------
package gshare_pkg;

  localparam int GS_ADDR_W = 11;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LOOKUP  = 2'd1,
    CAPTURE = 2'd2,
    UPDATE  = 2'd3
  } gs_state_e;

  typedef struct packed {
    logic [GS_ADDR_W-1:0] addr;
    logic                 pred;
  } gs_entry_t;

endpackage

// File: rtl/gshare_inflight_fifo.sv
// -----------------------------------------------------------------------------
// gshare_inflight_fifo
//   Circular synchronous FIFO holding in-flight predictions in program order.
//   Ports:
//     clk, reset  : rising-edge clock, synchronous active-high reset
//     push        : write push_data at the tail (ignored when full)
//     push_data   : entry to enqueue
//     pop         : drop the head entry (ignored when empty)
//     head_data   : oldest entry, valid whenever empty is low
//     full, empty : occupancy flags
//     count       : occupancy 0..DEPTH
// -----------------------------------------------------------------------------
module gshare_inflight_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 12
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             push_ok;
  logic             pop_ok;

  assign full      = (count_q == FULL_CNT);
  assign empty     = (count_q == '0);
  assign count     = count_q;
  assign head_data = mem_q[rd_ptr_q];

  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;

  // Pointers are exactly log2(DEPTH) bits, so they wrap on their own; the
  // separate count disambiguates full from empty when the pointers meet.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/gshare_ctrl.sv
// -----------------------------------------------------------------------------
// gshare_ctrl
//   Sequences a single-ported gshare predictor between fetch-side lookups and
//   resolve-side training updates. Predictions are queued in order and each
//   resolution trains the oldest one. Saturating statistics are kept.
//   Ports:
//     clk, reset                  : rising-edge clock, sync active-high reset
//     req_valid/req_addr/req_ready: fetch prediction request handshake
//     pred_valid/pred_taken       : one-cycle prediction result pulse
//     res_valid/res_taken/res_ready: resolution handshake (oldest branch)
//     pr_en/pr_we/pr_addr/pr_outcome: predictor access (we=1 train, 0 lookup)
//     pr_prediction               : predictor output, valid cycle after lookup
//     cnt_branches/cnt_mispred    : saturating resolved/mispredicted counters
//     err_underflow               : sticky, resolution seen with empty queue
// -----------------------------------------------------------------------------
module gshare_ctrl
  import gshare_pkg::*;
#(
  parameter int ADDR_W = GS_ADDR_W,
  parameter int DEPTH  = 4,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  input  logic [ADDR_W-1:0] req_addr,
  output logic              req_ready,
  output logic              pred_valid,
  output logic              pred_taken,
  input  logic              res_valid,
  input  logic              res_taken,
  output logic              res_ready,
  output logic              pr_en,
  output logic              pr_we,
  output logic [ADDR_W-1:0] pr_addr,
  output logic              pr_outcome,
  input  logic              pr_prediction,
  output logic [CNT_W-1:0]  cnt_branches,
  output logic [CNT_W-1:0]  cnt_mispred,
  output logic              err_underflow
);

  localparam int EW = ADDR_W + 1;

  gs_state_e         state_q, state_d;
  logic [ADDR_W-1:0] req_addr_q, req_addr_d;
  logic              resbuf_full_q, resbuf_full_d;
  logic              resbuf_taken_q, resbuf_taken_d;
  logic [CNT_W-1:0]  cnt_branches_q, cnt_branches_d;
  logic [CNT_W-1:0]  cnt_mispred_q, cnt_mispred_d;
  logic              err_underflow_q, err_underflow_d;
  logic [ADDR_W-1:0] pr_addr_q, pr_addr_d;
  logic              pr_outcome_q, pr_outcome_d;

  logic                   q_push;
  logic                   q_pop;
  logic [EW-1:0]          q_push_data;
  logic [EW-1:0]          q_head;
  logic                   q_full;
  logic                   q_empty;
  logic [$clog2(DEPTH):0] q_count;
  logic [ADDR_W-1:0]      head_addr;
  logic                   head_pred;
  logic                   req_fire;
  logic                   res_fire;

  gshare_inflight_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (EW)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (q_push),
    .push_data (q_push_data),
    .pop       (q_pop),
    .head_data (q_head),
    .full      (q_full),
    .empty     (q_empty),
    .count     (q_count)
  );

  assign q_push_data = {req_addr_q, pr_prediction};
  assign head_addr   = q_head[EW-1:1];
  assign head_pred   = q_head[0];

  assign req_ready = (state_q == IDLE) & ~q_full & ~resbuf_full_q;
  assign res_ready = ~resbuf_full_q;
  assign req_fire  = req_valid & req_ready;
  assign res_fire  = res_valid & res_ready;

  // pr_addr/pr_outcome are driven from the next-value path so the predictor
  // sees the new address in the strobe cycle; the registers keep the last
  // driven value visible while the controller is not accessing the array.
  assign pr_addr       = pr_addr_d;
  assign pr_outcome    = pr_outcome_d;
  assign cnt_branches  = cnt_branches_q;
  assign cnt_mispred   = cnt_mispred_q;
  assign err_underflow = err_underflow_q;

  always_comb begin
    state_d         = state_q;
    req_addr_d      = req_addr_q;
    resbuf_full_d   = resbuf_full_q;
    resbuf_taken_d  = resbuf_taken_q;
    cnt_branches_d  = cnt_branches_q;
    cnt_mispred_d   = cnt_mispred_q;
    err_underflow_d = err_underflow_q;
    pr_addr_d       = pr_addr_q;
    pr_outcome_d    = pr_outcome_q;
    pr_en           = 1'b0;
    pr_we           = 1'b0;
    pred_valid      = 1'b0;
    pred_taken      = 1'b0;
    q_push          = 1'b0;
    q_pop           = 1'b0;

    case (state_q)
      // A buffered resolution always wins over a new lookup so training is
      // never starved by a steady fetch stream.
      IDLE: begin
        if (resbuf_full_q) begin
          state_d = UPDATE;
        end else if (req_fire) begin
          req_addr_d = req_addr;
          state_d    = LOOKUP;
        end
      end
      LOOKUP: begin
        pr_en     = 1'b1;
        pr_addr_d = req_addr_q;
        state_d   = CAPTURE;
      end
      CAPTURE: begin
        pred_valid = 1'b1;
        pred_taken = pr_prediction;
        q_push     = 1'b1;
        state_d    = IDLE;
      end
      UPDATE: begin
        pr_en         = 1'b1;
        pr_we         = 1'b1;
        pr_addr_d     = head_addr;
        pr_outcome_d  = resbuf_taken_q;
        q_pop         = ~q_empty;
        resbuf_full_d = 1'b0;
        if (cnt_branches_q != '1) begin
          cnt_branches_d = cnt_branches_q + 1'b1;
        end
        if ((head_pred != resbuf_taken_q) && (cnt_mispred_q != '1)) begin
          cnt_mispred_d = cnt_mispred_q + 1'b1;
        end
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // A resolution is only meaningful if some prediction is (or is just now
    // becoming) outstanding; otherwise it is dropped and flagged.
    if (res_fire) begin
      if ((q_count != '0) || q_push) begin
        resbuf_full_d  = 1'b1;
        resbuf_taken_d = res_taken;
      end else begin
        err_underflow_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= IDLE;
      req_addr_q      <= '0;
      resbuf_full_q   <= 1'b0;
      resbuf_taken_q  <= 1'b0;
      cnt_branches_q  <= '0;
      cnt_mispred_q   <= '0;
      err_underflow_q <= 1'b0;
      pr_addr_q       <= '0;
      pr_outcome_q    <= 1'b0;
    end else begin
      state_q         <= state_d;
      req_addr_q      <= req_addr_d;
      resbuf_full_q   <= resbuf_full_d;
      resbuf_taken_q  <= resbuf_taken_d;
      cnt_branches_q  <= cnt_branches_d;
      cnt_mispred_q   <= cnt_mispred_d;
      err_underflow_q <= err_underflow_d;
      pr_addr_q       <= pr_addr_d;
      pr_outcome_q    <= pr_outcome_d;
    end
  end

endmodule

// File: tb/tb_gshare_ctrl.sv
// -----------------------------------------------------------------------------
// tb_gshare_ctrl
//   Directed bench for gshare_ctrl with a 2-bit counter width so that
//   saturation is reachable in a handful of branches. The bench drives the
//   predictor output itself.
// -----------------------------------------------------------------------------
module tb_gshare_ctrl;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic [10:0] req_addr;
  logic        req_ready;
  logic        pred_valid;
  logic        pred_taken;
  logic        res_valid;
  logic        res_taken;
  logic        res_ready;
  logic        pr_en;
  logic        pr_we;
  logic [10:0] pr_addr;
  logic        pr_outcome;
  logic        pr_prediction;
  logic [1:0]  cnt_branches;
  logic [1:0]  cnt_mispred;
  logic        err_underflow;

  int n_checks;
  int n_fails;

  gshare_ctrl #(
    .ADDR_W (11),
    .DEPTH  (4),
    .CNT_W  (2)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .req_valid     (req_valid),
    .req_addr      (req_addr),
    .req_ready     (req_ready),
    .pred_valid    (pred_valid),
    .pred_taken    (pred_taken),
    .res_valid     (res_valid),
    .res_taken     (res_taken),
    .res_ready     (res_ready),
    .pr_en         (pr_en),
    .pr_we         (pr_we),
    .pr_addr       (pr_addr),
    .pr_outcome    (pr_outcome),
    .pr_prediction (pr_prediction),
    .cnt_branches  (cnt_branches),
    .cnt_mispred   (cnt_mispred),
    .err_underflow (err_underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock and settle just after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset         = 1'b1;
    req_valid     = 1'b0;
    req_addr      = '0;
    res_valid     = 1'b0;
    res_taken     = 1'b0;
    pr_prediction = 1'b0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++; if (req_ready !== 1'b1) begin n_fails++; $display("[TB] FAIL rst_req_ready: got %0b expected 1", req_ready); end
    n_checks++; if (res_ready !== 1'b1) begin n_fails++; $display("[TB] FAIL rst_res_ready: got %0b expected 1", res_ready); end
    n_checks++; if ({pred_valid, pr_en, pr_we, pr_outcome} !== 4'b0) begin n_fails++; $display("[TB] FAIL rst_outputs: got %b expected 0000", {pred_valid, pr_en, pr_we, pr_outcome}); end
    n_checks++; if (pr_addr !== 11'h000) begin n_fails++; $display("[TB] FAIL rst_pr_addr: got %0h expected 0", pr_addr); end
    // Start a lookup, then reset in the middle of it.
    req_valid = 1'b1;
    req_addr  = 11'h155;
    tick();
    n_checks++; if (pr_en !== 1'b1) begin n_fails++; $display("[TB] FAIL rst_lookup_started: got %0b expected 1", pr_en); end
    reset     = 1'b1;
    req_valid = 1'b0;
    tick();
    n_checks++; if (pred_valid !== 1'b0 || pr_en !== 1'b0) begin n_fails++; $display("[TB] FAIL rst_abort: pred_valid=%0b pr_en=%0b expected 0 0", pred_valid, pr_en); end
    tick();
    reset = 1'b0;
    n_checks++; if (pred_valid !== 1'b0) begin n_fails++; $display("[TB] FAIL rst_hold_pred: got %0b expected 0", pred_valid); end
    tick();
    n_checks++; if (pred_valid !== 1'b0) begin n_fails++; $display("[TB] FAIL rst_no_pulse: got %0b expected 0", pred_valid); end
    n_checks++; if (req_ready !== 1'b1 || res_ready !== 1'b1) begin n_fails++; $display("[TB] FAIL rst_ready_after: got %0b%0b expected 11", req_ready, res_ready); end
    n_checks++; if (cnt_branches !== 2'd0 || cnt_mispred !== 2'd0 || err_underflow !== 1'b0) begin n_fails++; $display("[TB] FAIL rst_counters: got %0d %0d %0b expected 0 0 0", cnt_branches, cnt_mispred, err_underflow); end
  endtask

  task automatic test_single_branch();
    do_reset();
    req_valid = 1'b1;
    req_addr  = 11'h2A5;
    tick();
    req_valid     = 1'b0;
    pr_prediction = 1'b1;
    n_checks++; if (pr_en !== 1'b1 || pr_we !== 1'b0) begin n_fails++; $display("[TB] FAIL single_lookup_strobe: en=%0b we=%0b expected 1 0", pr_en, pr_we); end
    n_checks++; if (pr_addr !== 11'h2A5) begin n_fails++; $display("[TB] FAIL single_lookup_addr: got %0h expected 2a5", pr_addr); end
    n_checks++; if (pred_valid !== 1'b0) begin n_fails++; $display("[TB] FAIL single_early_pred: got %0b expected 0", pred_valid); end
    tick();
    n_checks++; if (pred_valid !== 1'b1 || pred_taken !== 1'b1) begin n_fails++; $display("[TB] FAIL single_pred: valid=%0b taken=%0b expected 1 1", pred_valid, pred_taken); end
    n_checks++; if (pr_en !== 1'b0) begin n_fails++; $display("[TB] FAIL single_capture_en: got %0b expected 0", pr_en); end
    // Resolution arrives together with the queue push.
    res_valid = 1'b1;
    res_taken = 1'b0;
    n_checks++; if (res_ready !== 1'b1) begin n_fails++; $display("[TB] FAIL single_res_ready: got %0b expected 1", res_ready); end
    tick();
    res_valid     = 1'b0;
    pr_prediction = 1'b0;
    n_checks++; if (pred_valid !== 1'b0 || res_ready !== 1'b0 || req_ready !== 1'b0) begin n_fails++; $display("[TB] FAIL single_buffered: pv=%0b rr=%0b qr=%0b expected 0 0 0", pred_valid, res_ready, req_ready); end
    tick();
    n_checks++; if (pr_en !== 1'b1 || pr_we !== 1'b1 || pr_addr !== 11'h2A5 || pr_outcome !== 1'b0) begin n_fails++; $display("[TB] FAIL single_update: en=%0b we=%0b addr=%0h out=%0b expected 1 1 2a5 0", pr_en, pr_we, pr_addr, pr_outcome); end
    tick();
    n_checks++; if (cnt_branches !== 2'd1 || cnt_mispred !== 2'd1) begin n_fails++; $display("[TB] FAIL single_counters: got %0d %0d expected 1 1", cnt_branches, cnt_mispred); end
    n_checks++; if (pr_en !== 1'b0 || pr_addr !== 11'h2A5) begin n_fails++; $display("[TB] FAIL single_idle_hold: en=%0b addr=%0h expected 0 2a5", pr_en, pr_addr); end
  endtask

  task automatic test_full_queue();
    do_reset();
    pr_prediction = 1'b1;
    for (int i = 0; i < 4; i++) begin
      n_checks++; if (req_ready !== 1'b1) begin n_fails++; $display("[TB] FAIL full_fill_ready[%0d]: got %0b expected 1", i, req_ready); end
      req_valid = 1'b1;
      req_addr  = 11'h100 + 11'(i);
      tick();
      req_valid = 1'b0;
      tick();
      n_checks++; if (pred_valid !== 1'b1) begin n_fails++; $display("[TB] FAIL full_fill_pred[%0d]: got %0b expected 1", i, pred_valid); end
      tick();
    end
    req_valid = 1'b1;
    req_addr  = 11'h1FF;
    n_checks++; if (req_ready !== 1'b0) begin n_fails++; $display("[TB] FAIL full_not_ready: got %0b expected 0", req_ready); end
    tick();
    n_checks++; if (pr_en !== 1'b0) begin n_fails++; $display("[TB] FAIL full_no_lookup: got %0b expected 0", pr_en); end
    res_valid = 1'b1;
    res_taken = 1'b1;
    tick();
    res_valid = 1'b0;
    n_checks++; if (req_ready !== 1'b0 || pr_en !== 1'b0) begin n_fails++; $display("[TB] FAIL full_res_buffered: qr=%0b en=%0b expected 0 0", req_ready, pr_en); end
    tick();
    n_checks++; if (pr_en !== 1'b1 || pr_we !== 1'b1 || pr_addr !== 11'h100) begin n_fails++; $display("[TB] FAIL full_update: en=%0b we=%0b addr=%0h expected 1 1 100", pr_en, pr_we, pr_addr); end
    tick();
    n_checks++; if (pr_en !== 1'b0 || req_ready !== 1'b1) begin n_fails++; $display("[TB] FAIL full_one_update: en=%0b qr=%0b expected 0 1", pr_en, req_ready); end
    n_checks++; if (cnt_branches !== 2'd1 || cnt_mispred !== 2'd0) begin n_fails++; $display("[TB] FAIL full_counters: got %0d %0d expected 1 0", cnt_branches, cnt_mispred); end
    req_valid = 1'b0;
    // Drain the remaining three entries in order, each mispredicted.
    for (int i = 0; i < 3; i++) begin
      res_valid = 1'b1;
      res_taken = 1'b0;
      tick();
      res_valid = 1'b0;
      tick();
      n_checks++; if (pr_we !== 1'b1 || pr_addr !== (11'h101 + 11'(i))) begin n_fails++; $display("[TB] FAIL full_drain[%0d]: we=%0b addr=%0h expected 1 %0h", i, pr_we, pr_addr, 11'h101 + 11'(i)); end
      tick();
    end
    n_checks++; if (cnt_branches !== 2'd3 || cnt_mispred !== 2'd3) begin n_fails++; $display("[TB] FAIL full_drain_counters: got %0d %0d expected 3 3", cnt_branches, cnt_mispred); end
  endtask

  task automatic test_priority_order();
    do_reset();
    pr_prediction = 1'b0;
    req_valid = 1'b1;
    req_addr  = 11'h010;
    tick();
    req_valid = 1'b0;
    tick();
    tick();
    req_valid = 1'b1;
    req_addr  = 11'h020;
    tick();
    // Keep a new request pending while a resolution is buffered.
    req_addr  = 11'h030;
    res_valid = 1'b1;
    res_taken = 1'b0;
    tick();
    res_valid = 1'b0;
    tick();
    n_checks++; if (req_ready !== 1'b0) begin n_fails++; $display("[TB] FAIL prio_req_blocked: got %0b expected 0", req_ready); end
    tick();
    n_checks++; if (pr_en !== 1'b1 || pr_we !== 1'b1 || pr_addr !== 11'h010 || pr_outcome !== 1'b0) begin n_fails++; $display("[TB] FAIL prio_update_first: en=%0b we=%0b addr=%0h out=%0b expected 1 1 10 0", pr_en, pr_we, pr_addr, pr_outcome); end
    tick();
    n_checks++; if (req_ready !== 1'b1 || pr_en !== 1'b0) begin n_fails++; $display("[TB] FAIL prio_idle_after: qr=%0b en=%0b expected 1 0", req_ready, pr_en); end
    tick();
    n_checks++; if (pr_en !== 1'b1 || pr_we !== 1'b0 || pr_addr !== 11'h030) begin n_fails++; $display("[TB] FAIL prio_lookup_after: en=%0b we=%0b addr=%0h expected 1 0 30", pr_en, pr_we, pr_addr); end
    req_valid = 1'b0;
    res_valid = 1'b1;
    res_taken = 1'b1;
    tick();
    res_valid = 1'b0;
    tick();
    tick();
    n_checks++; if (pr_we !== 1'b1 || pr_addr !== 11'h020 || pr_outcome !== 1'b1) begin n_fails++; $display("[TB] FAIL order_second: we=%0b addr=%0h out=%0b expected 1 20 1", pr_we, pr_addr, pr_outcome); end
    tick();
    res_valid = 1'b1;
    res_taken = 1'b0;
    tick();
    res_valid = 1'b0;
    tick();
    n_checks++; if (pr_we !== 1'b1 || pr_addr !== 11'h030 || pr_outcome !== 1'b0) begin n_fails++; $display("[TB] FAIL order_third: we=%0b addr=%0h out=%0b expected 1 30 0", pr_we, pr_addr, pr_outcome); end
    tick();
    n_checks++; if (cnt_branches !== 2'd3 || cnt_mispred !== 2'd1) begin n_fails++; $display("[TB] FAIL order_counters: got %0d %0d expected 3 1", cnt_branches, cnt_mispred); end
  endtask

  task automatic test_underflow();
    do_reset();
    res_valid = 1'b1;
    res_taken = 1'b1;
    n_checks++; if (res_ready !== 1'b1 || err_underflow !== 1'b0) begin n_fails++; $display("[TB] FAIL uflow_pre: rr=%0b err=%0b expected 1 0", res_ready, err_underflow); end
    tick();
    res_valid = 1'b0;
    n_checks++; if (err_underflow !== 1'b1) begin n_fails++; $display("[TB] FAIL uflow_flag: got %0b expected 1", err_underflow); end
    n_checks++; if (res_ready !== 1'b1 || pr_en !== 1'b0) begin n_fails++; $display("[TB] FAIL uflow_dropped: rr=%0b en=%0b expected 1 0", res_ready, pr_en); end
    tick();
    n_checks++; if (pr_en !== 1'b0 || cnt_branches !== 2'd0) begin n_fails++; $display("[TB] FAIL uflow_no_update: en=%0b branches=%0d expected 0 0", pr_en, cnt_branches); end
    tick();
    tick();
    n_checks++; if (err_underflow !== 1'b1) begin n_fails++; $display("[TB] FAIL uflow_sticky: got %0b expected 1", err_underflow); end
  endtask

  task automatic test_saturation();
    logic [1:0] exp_cnt;
    do_reset();
    n_checks++; if (err_underflow !== 1'b0) begin n_fails++; $display("[TB] FAIL sat_err_cleared: got %0b expected 0", err_underflow); end
    pr_prediction = 1'b1;
    for (int i = 0; i < 5; i++) begin
      req_valid = 1'b1;
      req_addr  = 11'h040 + 11'(i);
      tick();
      req_valid = 1'b0;
      tick();
      tick();
      res_valid = 1'b1;
      res_taken = 1'b0;
      tick();
      res_valid = 1'b0;
      tick();
      tick();
      exp_cnt = (i >= 2) ? 2'd3 : 2'(i + 1);
      n_checks++; if (cnt_branches !== exp_cnt || cnt_mispred !== exp_cnt) begin n_fails++; $display("[TB] FAIL sat_step[%0d]: got %0d %0d expected %0d %0d", i, cnt_branches, cnt_mispred, exp_cnt, exp_cnt); end
    end
  endtask

  initial begin
    n_checks = 0;
    n_fails  = 0;
    $display("[TB] gshare_ctrl directed bench start");
    test_reset();
    test_single_branch();
    test_full_queue();
    test_priority_order();
    test_underflow();
    test_saturation();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
